// File: rtl/i2s_rx_if.sv
// AXI4-Stream audio word bus carried out of the I2S receiver.
// master: the receiver driving words out; slave: the consuming sink.
interface i2s_rx_if;
  logic [31:0] m_axis_aud_tdata;
  logic [2:0]  m_axis_aud_tid;
  logic        m_axis_aud_tvalid;
  logic        m_axis_aud_tready;

  modport master (
    output m_axis_aud_tdata,
    output m_axis_aud_tid,
    output m_axis_aud_tvalid,
    input  m_axis_aud_tready
  );

  modport slave (
    input  m_axis_aud_tdata,
    input  m_axis_aud_tid,
    input  m_axis_aud_tvalid,
    output m_axis_aud_tready
  );
endinterface

// File: rtl/i2s_rx.sv
// I2S capture block: oversamples sclk/lrclk/sdata in the stream clock
// domain, deserializes one channel word per LR half-frame and buffers
// words in a 2-entry FIFO feeding an AXI4-Stream audio sink.
// Optional build macro: I2S_RX_LEFT_JUSTIFIED_EN selects left-justified
// input format (lr high = left); undefined gives standard I2S.
module i2s_rx #(
  parameter int DATA_WIDTH = 24
) (
  input  logic     m_axis_aud_aclk,
  input  logic     m_axis_aud_aresetn,
  input  logic     enable,
  input  logic     sclk_in,
  input  logic     lrclk_in,
  input  logic     sdata_0_in,
  output logic     overflow,
  input  logic     overflow_clr,
  i2s_rx_if.master m_axis
);

  localparam int W   = DATA_WIDTH;
  localparam int PAD = 28 - DATA_WIDTH;

  typedef enum logic [1:0] {
    DISABLED  = 2'd0,
    WAIT_EDGE = 2'd1,
    RUN       = 2'd2
  } state_t;

  // ---------------- pin synchronizers and bit-clock edge detect ----------
  logic [1:0] sclk_sync_q;
  logic [1:0] lr_sync_q;
  logic [1:0] sd_sync_q;
  logic       sclk_dly_q;
  logic       sclk_rise;
  logic       lr_s;
  logic       sd_s;

  // Two-flop synchronizers on all three pins plus one delay stage on sclk.
  always_ff @(posedge m_axis_aud_aclk or negedge m_axis_aud_aresetn) begin
    if (!m_axis_aud_aresetn) begin
      sclk_sync_q <= 2'b00;
      lr_sync_q   <= 2'b00;
      sd_sync_q   <= 2'b00;
      sclk_dly_q  <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], sclk_in};
      lr_sync_q   <= {lr_sync_q[0], lrclk_in};
      sd_sync_q   <= {sd_sync_q[0], sdata_0_in};
      sclk_dly_q  <= sclk_sync_q[1];
    end
  end

  assign sclk_rise = sclk_sync_q[1] & ~sclk_dly_q;
  assign lr_s      = lr_sync_q[1];
  assign sd_s      = sd_sync_q[1];

  // ---------------- deserializer ----------------------------------------
  state_t       state_q;
  logic [5:0]   bitcnt_q;
  logic [W-1:0] shreg_q;
  logic         lr_prev_q;
  logic         push_q;
  logic [W-1:0] push_data_q;
  logic         push_tid_q;
  logic         lr_change;
  logic [W-1:0] bit_vec;
  logic [W-1:0] shreg_shift;

  assign lr_change = (lr_s != lr_prev_q);

  // Place the sampled bit at position W-1-bitcnt; nothing lands once
  // bitcnt reaches W, so surplus slot bits are ignored and short slots
  // leave the LSBs zero-padded.
  always_comb begin
    bit_vec = '0;
    for (int i = 0; i < W; i++) begin
      bit_vec[i] = sd_s && (int'(bitcnt_q) == (W - 1 - i));
    end
  end

  assign shreg_shift = shreg_q | bit_vec;

`ifdef I2S_RX_LEFT_JUSTIFIED_EN
  logic [W-1:0] msb_vec;
  assign msb_vec = {sd_s, {(W-1){1'b0}}};
`endif

  // Capture FSM: tracks lr, counts bits, shifts data and emits a push pulse.
  always_ff @(posedge m_axis_aud_aclk or negedge m_axis_aud_aresetn) begin
    if (!m_axis_aud_aresetn) begin
      state_q     <= DISABLED;
      bitcnt_q    <= 6'd0;
      shreg_q     <= '0;
      lr_prev_q   <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      push_tid_q  <= 1'b0;
    end else begin
      push_q <= 1'b0;
      // lr_prev follows the line even while disabled so that the first
      // lr change seen in WAIT_EDGE is a real one.
      if (sclk_rise) begin
        lr_prev_q <= lr_s;
      end
      if (!enable) begin
        state_q  <= DISABLED;
        bitcnt_q <= 6'd0;
        shreg_q  <= '0;
      end else begin
        case (state_q)
          DISABLED: begin
            state_q  <= WAIT_EDGE;
            bitcnt_q <= 6'd0;
            shreg_q  <= '0;
          end
          WAIT_EDGE: begin
            if (sclk_rise && lr_change) begin
              state_q <= RUN;
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
              bitcnt_q <= 6'd1;
              shreg_q  <= msb_vec;
`else
              bitcnt_q <= 6'd0;
              shreg_q  <= '0;
`endif
            end
          end
          RUN: begin
            if (sclk_rise) begin
              if (lr_change) begin
                push_q <= 1'b1;
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
                // Edge bit is the MSB of the new channel.
                push_data_q <= shreg_q;
                push_tid_q  <= ~lr_prev_q;
                bitcnt_q    <= 6'd1;
                shreg_q     <= msb_vec;
`else
                // Edge bit is the LSB of the ending channel.
                push_data_q <= shreg_shift;
                push_tid_q  <= lr_prev_q;
                bitcnt_q    <= 6'd0;
                shreg_q     <= '0;
`endif
              end else begin
                shreg_q <= shreg_shift;
                if (bitcnt_q != 6'd63) begin
                  bitcnt_q <= bitcnt_q + 6'd1;
                end
              end
            end
          end
          default: begin
            state_q <= DISABLED;
          end
        endcase
      end
    end
  end

  // ---------------- 2-entry output FIFO ---------------------------------
  logic [W:0] mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic       full;
  logic       valid;
  logic       pop;
  logic       wr_en;
  logic       drop;
  logic [W:0] head;

  assign full  = (count_q == 2'd2);
  assign valid = (count_q != 2'd0);
  assign pop   = valid && m_axis.m_axis_aud_tready;
  // When full, a simultaneous pop frees the slot being written.
  assign wr_en = push_q && (!full || pop);
  assign drop  = push_q && full && !pop;

  // Occupancy next-state.
  always_comb begin
    count_d = count_q;
    if (wr_en && !pop) begin
      count_d = count_q + 2'd1;
    end else if (!wr_en && pop) begin
      count_d = count_q - 2'd1;
    end
  end

  // FIFO storage, pointers and sticky overflow flag.
  always_ff @(posedge m_axis_aud_aclk or negedge m_axis_aud_aresetn) begin
    if (!m_axis_aud_aresetn) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= {push_tid_q, push_data_q};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
      if (drop) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  assign head                     = mem_q[rd_ptr_q];
  assign m_axis.m_axis_aud_tvalid = valid;
  assign m_axis.m_axis_aud_tdata  = {4'b0000, head[W-1:0], {PAD{1'b0}}};
  assign m_axis.m_axis_aud_tid    = {2'b00, head[W]};

endmodule
